// File: rtl/condlogic_if.sv
// condlogic_if: signal bundle between the controller (master) and the
// conditional-execution unit (slave).
//   master drives: Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW
//   master reads : PCWrite, RegWrite, MemWrite, Flags, CondEx
// There is no valid/ready handshake here. Every request (FlagW, PCS,
// NextPC, RegW, MemW) is a level-sensitive enable that applies in the cycle
// it is asserted. The gated enables answer combinationally in that same cycle.
interface condlogic_if;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx
  );
endinterface

// File: rtl/condlogic.sv
// condlogic: conditional-execution unit for the multicycle ARM datapath.
// It holds the NZCV flags and evaluates the instruction condition field
// against them. It then gates the register, memory and PC write enables.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - condlogic_if.slave (condition, ALU flags, write requests in;
//           gated enables, Flags and CondEx out)
module condlogic (
  input  logic           clk,
  input  logic           reset,
  condlogic_if.slave     bus
);

  logic [3:0] flags_q;
  logic       condex_q;
  logic       condex_c;
  logic       n, z, c, v;
  logic [1:0] flag_write;

  // The condition is always evaluated against the registered flags. That
  // way a flag-setting instruction tests its own condition on the old flags.
  assign {n, z, c, v} = flags_q;

  always_comb begin
    condex_c = 1'b0;
    case (bus.Cond)
      4'b0000: condex_c = z;
      4'b0001: condex_c = ~z;
      4'b0010: condex_c = c;
      4'b0011: condex_c = ~c;
      4'b0100: condex_c = n;
      4'b0101: condex_c = ~n;
      4'b0110: condex_c = v;
      4'b0111: condex_c = ~v;
      4'b1000: condex_c = c & ~z;
      4'b1001: condex_c = ~c | z;
      4'b1010: condex_c = ~(n ^ v);
      4'b1011: condex_c = n ^ v;
      4'b1100: condex_c = ~z & ~(n ^ v);
      4'b1101: condex_c = z | (n ^ v);
      4'b1110: condex_c = 1'b1;
      default: condex_c = 1'b0;  // 1111 reserved: never execute
    endcase
  end

  assign flag_write = bus.FlagW & {2{condex_c}};

  // The N/Z pair and the C/V pair update independently. Reset wins over
  // any pending flag write.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q  <= 4'b0000;
      condex_q <= 1'b0;
    end else begin
      if (flag_write[1]) flags_q[3:2] <= bus.ALUFlags[3:2];
      if (flag_write[0]) flags_q[1:0] <= bus.ALUFlags[1:0];
      condex_q <= condex_c;
    end
  end

  assign bus.Flags    = flags_q;
  assign bus.CondEx   = condex_q;
  assign bus.RegWrite = bus.RegW & condex_q;
  assign bus.MemWrite = bus.MemW & condex_q;
  // Fetch increment is never gated, so the PC always advances.
  assign bus.PCWrite  = bus.NextPC | (bus.PCS & condex_q);

endmodule

// File: tb/tb_condlogic.sv
module tb_condlogic;

  logic clk;
  logic reset;
  condlogic_if bus();

  condlogic dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Conditions come in complementary pairs: the upper three bits pick a base
  // test and bit 0 inverts it. 1110 is always, 1111 is never.
  function automatic logic mpass(input logic [3:0] cnd, input logic [3:0] f);
    logic fn, fz, fc, fv, base;
    {fn, fz, fc, fv} = f;
    base = 1'b1;
    case (cnd[3:1])
      3'd0: base = fz;
      3'd1: base = fc;
      3'd2: base = fn;
      3'd3: base = fv;
      3'd4: base = fc && !fz;
      3'd5: base = (fn == fv);
      3'd6: base = !fz && (fn == fv);
      default: base = 1'b1;
    endcase
    if (cnd == 4'b1111) return 1'b0;
    return cnd[0] ? !base : base;
  endfunction

  logic [3:0] m_flags;
  logic       m_condex;
  bit         m_valid = 0;
  logic [4:0] exp_q[$];

  always @(posedge clk) begin
    logic p;
    if (reset) begin
      m_flags  = 4'b0000;
      m_condex = 1'b0;
      m_valid  = 1;
    end else if (m_valid) begin
      p = mpass(bus.Cond, m_flags);
      if (p && bus.FlagW[1]) m_flags[3:2] = bus.ALUFlags[3:2];
      if (p && bus.FlagW[0]) m_flags[1:0] = bus.ALUFlags[1:0];
      m_condex = p;
    end
    if (m_valid) exp_q.push_back({m_flags, m_condex});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [4:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_flags",  bus.Flags, e[4:1]);
      check("sb_condex", {3'b0, bus.CondEx}, {3'b0, e[0]});
      check("sb_regwrite", {3'b0, bus.RegWrite}, {3'b0, bus.RegW & e[0]});
      check("sb_memwrite", {3'b0, bus.MemWrite}, {3'b0, bus.MemW & e[0]});
      check("sb_pcwrite",  {3'b0, bus.PCWrite},
            {3'b0, bus.NextPC | (bus.PCS & e[0])});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic [3:0] cnd, input logic [3:0] af,
                       input logic [1:0] fw, input logic pcs, input logic npc,
                       input logic rw, input logic mw);
    reset        = rst;
    bus.Cond     = cnd;
    bus.ALUFlags = af;
    bus.FlagW    = fw;
    bus.PCS      = pcs;
    bus.NextPC   = npc;
    bus.RegW     = rw;
    bus.MemW     = mw;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1);
    // Reset for two edges with a flag write pending.
    step(); step();
    check("rst_flags", bus.Flags, 4'b0000);
    check("rst_condex", {3'b0, bus.CondEx}, 4'b0000);
    check("rst_regwrite", {3'b0, bus.RegWrite}, 4'b0000);
    check("rst_memwrite", {3'b0, bus.MemWrite}, 4'b0000);
    check("rst_pcwrite", {3'b0, bus.PCWrite}, 4'b0000);

    // Flag capture under AL.
    drive(1'b0, 4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("cap_flags", bus.Flags, 4'b0110);
    // EQ with Z=1 passes.
    drive(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("eq_condex", {3'b0, bus.CondEx}, 4'b0001);
    bus.RegW = 1'b1; #1;
    check("eq_regwrite", {3'b0, bus.RegWrite}, 4'b0001);

    // Partial write: N,Z only.
    drive(1'b0, 4'b1110, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("partial_flags", bus.Flags, 4'b1010);

    // Failed condition suppression.
    drive(1'b0, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("setz_flags", bus.Flags, 4'b0100);
    drive(1'b0, 4'b0001, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("ne_fail_flags", bus.Flags, 4'b0100);
    check("ne_fail_condex", {3'b0, bus.CondEx}, 4'b0000);
    bus.RegW = 1'b1; bus.MemW = 1'b1; bus.PCS = 1'b1; bus.NextPC = 1'b0; #1;
    check("sup_gated", {1'b0, bus.RegWrite, bus.MemWrite, bus.PCWrite}, 4'b0000);

    // Branch gating.
    bus.NextPC = 1'b1; #1;
    check("br_npc", {3'b0, bus.PCWrite}, 4'b0001);
    bus.NextPC = 1'b0; #1;
    check("br_fail", {3'b0, bus.PCWrite}, 4'b0000);
    drive(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    check("br_taken", {3'b0, bus.PCWrite}, 4'b0001);

    // Full sweep: every condition against every flag value.
    for (int f = 0; f < 16; f++) begin
      drive(1'b0, 4'b1110, f[3:0], 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      for (int c = 0; c < 16; c++) begin
        drive(1'b0, c[3:0], 4'($urandom_range(0, 15)), 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        if (c == 15) check("nv_never", {3'b0, bus.CondEx}, 4'b0000);
      end
    end

    // GE/LT pinned by hand.
    drive(1'b0, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check("ge_n1v1", {3'b0, bus.CondEx}, 4'b0001);
    drive(1'b0, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check("lt_n1v1", {3'b0, bus.CondEx}, 4'b0000);
    drive(1'b0, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check("ge_n1v0", {3'b0, bus.CondEx}, 4'b0000);
    drive(1'b0, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check("lt_n1v0", {3'b0, bus.CondEx}, 4'b0001);

    // Randomized traffic, with occasional mid-stream resets.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
    end

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/condlogic.md
# condlogic

Conditional-execution unit for the multicycle ARM datapath. It holds the NZCV status flags produced by `alu` and evaluates each instruction's 4-bit condition field against them. It gates the controller's register, memory and PC write enables so that a failed condition suppresses every architectural side effect. It sits between the main FSM/decoder and the register file, memory and PC enables, and consumes `ALUFlags` from the ALU.

## Interface
Parameters:
- none. Widths are fixed by the ISA.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `Cond` input 4: condition field, instruction bits [31:28].
- `ALUFlags` input 4: {N, Z, C, V} from `alu`, valid in the cycle the ALU result is used.
- `FlagW` input 2: flag-write request from the decoder. Bit 1 writes N,Z; bit 0 writes C,V.
- `PCS` input 1: instruction writes the PC (branch, or a data-processing op to R15).
- `NextPC` input 1: FSM fetch-state PC increment; unconditional.
- `RegW` input 1: FSM register-file write request.
- `MemW` input 1: FSM memory write request.
- `PCWrite` output 1: gated PC enable.
- `RegWrite` output 1: gated register-file enable.
- `MemWrite` output 1: gated memory enable.
- `Flags` output 4: current architectural {N, Z, C, V}.
- `CondEx` output 1: registered condition-pass bit for the instruction in flight.

## Operation
- Combinational condition pass `condex_c` is computed from `Cond` and the registered `Flags`, never from `ALUFlags`:
  - EQ 0000 Z; NE 0001 !Z
  - CS 0010 C; CC 0011 !C
  - MI 0100 N; PL 0101 !N
  - VS 0110 V; VC 0111 !V
  - HI 1000 C&!Z; LS 1001 !C|Z
  - GE 1010 N==V; LT 1011 N!=V
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V)
  - AL 1110 1
  - 1111 is reserved and evaluates to 0 (never execute).
- Flag write enables: `FlagWrite[1] = FlagW[1] & condex_c` and `FlagWrite[0] = FlagW[0] & condex_c`.
- Flag registers: on `FlagWrite[1]`, Flags[3:2] <= ALUFlags[3:2]. On `FlagWrite[0]`, Flags[1:0] <= ALUFlags[1:0]. Each pair updates independently.
- CondEx register loads `condex_c` every cycle with no enable. It is stable through the later FSM states of the instruction, after the flags may have changed.
- Output gating uses the registered `CondEx`:
  - `RegWrite = RegW & CondEx`
  - `MemWrite = MemW & CondEx`
  - `PCWrite = NextPC | (PCS & CondEx)`
- `NextPC` is never gated, so fetch always advances.

## Timing
- Reset (synchronous; takes effect at the first rising edge with `reset`=1):
  - `Flags`=4'b0000, `CondEx`=0.
  - `RegWrite`=0 and `MemWrite`=0.
  - `PCWrite` equals `NextPC` (combinational pass-through).
- Reset has priority over any `FlagW` in the same cycle. Reset asserted mid-instruction discards any pending flag update and clears `CondEx`.
- Latency:
  - Flags are visible on `Flags` one cycle after the edge that samples `FlagWrite`.
  - `CondEx` reflects the `Cond`/`Flags` of the previous cycle.
  - Gated outputs are combinational from `CondEx` and the FSM inputs (zero added latency).
- The condition is evaluated against pre-update flags. A flag-setting instruction checks its own condition against the old flags, and the new flags apply from the next cycle.
- Simultaneous `FlagW`=2'b11 with a failed condition: no flag bit changes.
- `FlagW`=2'b10: C and V hold their previous values even if `ALUFlags[1:0]` differ.
- All outputs are free of X after the first reset edge. `Cond`=1111 never produces X.

## Test plan
- Reset check: assert `reset` for 2 cycles with `FlagW`=11 and `ALUFlags`=1111.
  - Required: `Flags`=0000, `CondEx`=0.
  - Required with `NextPC`=0: `RegWrite`=0, `MemWrite`=0, `PCWrite`=0.
- Flag capture: `Cond`=1110, `FlagW`=11, `ALUFlags`=0110.
  - Next cycle: `Flags`=0110.
  - Then `Cond`=0000 (EQ): `CondEx`=1 one cycle later.
  - With `RegW`=1: `RegWrite`=1.
- Partial write: from `Flags`=0110, apply `FlagW`=10 with `ALUFlags`=1001.
  - Required: `Flags`=1010 (N,Z updated; C,V held).
- Failed condition suppression: `Flags`=0100, `Cond`=0001 (NE), `FlagW`=11, `ALUFlags`=1000.
  - `Flags` stays 0100.
  - `CondEx`=0 next cycle.
  - With `RegW`=`MemW`=`PCS`=1 and `NextPC`=0: all three gated outputs are 0.
- Full condition sweep: for every `Cond` 0000–1111 against all 16 `Flags` values, `CondEx` matches the table. GE/LT are checked at N=1,V=1 (GE passes) and N=1,V=0 (LT passes). 1111 is always 0.
- Branch gating: `CondEx`=0, `PCS`=1, `NextPC`=1 gives `PCWrite`=1. `CondEx`=1, `PCS`=1, `NextPC`=0 gives `PCWrite`=1. `CondEx`=0, `PCS`=1, `NextPC`=0 gives `PCWrite`=0.
